// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router packet transmitter: FSM state encoding,
// maximum payload length and header field widths, plus a helper that
// assembles the header byte {len, addr}.
package router_pkg;

  localparam int ROUTER_MAX_LEN   = 63;
  localparam int ROUTER_ADDR_W    = 2;
  localparam int ROUTER_LEN_W     = 6;
  localparam int ROUTER_DATA_W    = 8;
  localparam int ROUTER_BUF_DEPTH = ROUTER_MAX_LEN + 1;
  localparam int ROUTER_IDX_W     = $clog2(ROUTER_BUF_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_DONE    = 3'd5
  } router_tx_state_t;

  function automatic logic [ROUTER_DATA_W-1:0] router_header(
    input logic [ROUTER_LEN_W-1:0]  len,
    input logic [ROUTER_ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf
// Payload storage for one packet: 64 x 8 register array with one synchronous
// write port and one asynchronous read port. Contents are never reset.
// Ports:
//   clk      clock
//   wr_en    write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  write index
//   wr_data  write byte
//   rd_addr  read index
//   rd_data  byte at rd_addr (combinational)
module router_tx_buf
  import router_pkg::*;
(
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ROUTER_IDX_W-1:0]  wr_addr,
  input  logic [ROUTER_DATA_W-1:0] wr_data,
  input  logic [ROUTER_IDX_W-1:0]  rd_addr,
  output logic [ROUTER_DATA_W-1:0] rd_data
);

  logic [ROUTER_DATA_W-1:0] mem [ROUTER_BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// Packet transmitter towards the router. A request (addr, len) is accepted,
// the whole payload is buffered first, then header, payload and a trailing
// XOR parity byte are streamed without gaps, honouring router busy.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   req_valid/ready     request handshake, req_addr (0..3), req_len (0..63)
//   pld_valid/ready     payload byte handshake, pld_data
//   busy                router busy: hold the current output byte
//   data_out, pkt_valid byte to router; pkt_valid high for header + payload
//   tx_done             one-cycle pulse when the packet is complete
//   err, err_cnt        router parity-error flag and its saturating count
//   par_inj             only with ROUTER_TX_PAR_INJ_EN defined: sampled at
//                       request acceptance, inverts the parity byte
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a request, req_ready high
// ST_FILL    | accepting len payload bytes into the buffer
// ST_HEADER  | presenting header {len, addr}
// ST_PAYLOAD | presenting buffer[rd_idx], parity accumulates on consume
// ST_PARITY  | presenting parity byte, pkt_valid low
// ST_DONE    | tx_done pulse, back to idle
module router_pkt_tx
  import router_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ROUTER_ADDR_W-1:0] req_addr,
  input  logic [ROUTER_LEN_W-1:0]  req_len,
  input  logic                     pld_valid,
  output logic                     pld_ready,
  input  logic [ROUTER_DATA_W-1:0] pld_data,
  input  logic                     busy,
  output logic [ROUTER_DATA_W-1:0] data_out,
  output logic                     pkt_valid,
  output logic                     tx_done,
  input  logic                     err,
`ifdef ROUTER_TX_PAR_INJ_EN
  input  logic                     par_inj,
`endif
  output logic [7:0]               err_cnt
);

  router_tx_state_t          state;
  logic [ROUTER_ADDR_W-1:0]  addr_q;
  logic [ROUTER_LEN_W-1:0]   len_q;
  logic [ROUTER_DATA_W-1:0]  parity_q;
  logic [ROUTER_IDX_W-1:0]   wr_idx;
  logic [ROUTER_IDX_W-1:0]   rd_idx;
  logic [ROUTER_IDX_W-1:0]   rd_addr;
  logic [ROUTER_DATA_W-1:0]  rd_data;
  logic [ROUTER_DATA_W-1:0]  parity_nxt;
  logic                      buf_wr_en;
  logic                      inj;

`ifdef ROUTER_TX_PAR_INJ_EN
  logic par_inj_q;
  assign inj = par_inj_q;
`else
  assign inj = 1'b0;
`endif

  assign buf_wr_en = (state == ST_FILL) && pld_valid;

  // data_out is registered, so the buffer is read one byte ahead: in HEADER
  // the next byte is buffer[0], in PAYLOAD it is buffer[rd_idx+1].
  assign rd_addr = (state == ST_PAYLOAD) ? rd_idx + 6'd1 : '0;

  // In PAYLOAD data_out holds buffer[rd_idx], the byte being consumed.
  assign parity_nxt = parity_q ^ data_out;

  router_tx_buf u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_idx),
    .wr_data (pld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      parity_q  <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      req_ready <= 1'b1;
      pld_ready <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_done   <= 1'b0;
`ifdef ROUTER_TX_PAR_INJ_EN
      par_inj_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            len_q     <= req_len;
            parity_q  <= router_header(req_len, req_addr);
            wr_idx    <= '0;
            rd_idx    <= '0;
            req_ready <= 1'b0;
`ifdef ROUTER_TX_PAR_INJ_EN
            par_inj_q <= par_inj;
`endif
            if (req_len != '0) begin
              state     <= ST_FILL;
              pld_ready <= 1'b1;
            end else begin
              state     <= ST_HEADER;
              pkt_valid <= 1'b1;
              data_out  <= router_header(req_len, req_addr);
            end
          end
        end

        ST_FILL: begin
          if (pld_valid) begin
            wr_idx <= wr_idx + 6'd1;
            if (wr_idx == len_q - 6'd1) begin
              state     <= ST_HEADER;
              pld_ready <= 1'b0;
              pkt_valid <= 1'b1;
              data_out  <= router_header(len_q, addr_q);
            end
          end
        end

        ST_HEADER: begin
          if (!busy) begin
            if (len_q != '0) begin
              state    <= ST_PAYLOAD;
              data_out <= rd_data;
            end else begin
              state     <= ST_PARITY;
              pkt_valid <= 1'b0;
              data_out  <= inj ? ~parity_q : parity_q;
            end
          end
        end

        ST_PAYLOAD: begin
          if (!busy) begin
            parity_q <= parity_nxt;
            rd_idx   <= rd_idx + 6'd1;
            if (rd_idx == len_q - 6'd1) begin
              state     <= ST_PARITY;
              pkt_valid <= 1'b0;
              data_out  <= inj ? ~parity_nxt : parity_nxt;
            end else begin
              data_out <= rd_data;
            end
          end
        end

        ST_PARITY: begin
          if (!busy) begin
            state    <= ST_DONE;
            data_out <= '0;
            tx_done  <= 1'b1;
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          tx_done   <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          pld_ready <= 1'b0;
          pkt_valid <= 1'b0;
          data_out  <= '0;
          tx_done   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = '0;
  logic [5:0] req_len = '0;
  logic       pld_valid = 1'b0;
  logic       pld_ready;
  logic [7:0] pld_data = '0;
  logic       busy = 1'b0;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_done;
  logic       err = 1'b0;
  logic [7:0] err_cnt;
`ifdef ROUTER_TX_PAR_INJ_EN
  logic       par_inj = 1'b0;
`endif

  always #5 clk = ~clk;

  router_pkt_tx dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pld_valid (pld_valid),
    .pld_ready (pld_ready),
    .pld_data  (pld_data),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_done   (tx_done),
    .err       (err),
`ifdef ROUTER_TX_PAR_INJ_EN
    .par_inj   (par_inj),
`endif
    .err_cnt   (err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard entries are {pkt_valid, byte}.
  logic [8:0] sb[$];
  logic [8:0] exp_e;
  logic [7:0] pld_buf[64];

  int   run_len      = 0;
  int   last_run     = 0;
  int   overlap      = 0;
  int   pld_rdy_seen = 0;
  int   tx_cnt       = 0;
  logic prev_pv      = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_busy    = 1'b0;

  // A byte is consumed at the next posedge when shown with busy low.
  always @(negedge clk) begin
    if (rst) begin
      if (pkt_valid && !busy) begin
        if (sb.size() == 0) check_val("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          exp_e = sb.pop_front();
          check_val("stream_byte", 32'({pkt_valid, data_out}), 32'(exp_e));
        end
      end
      if (tx_done) begin
        tx_cnt++;
        if (sb.size() == 0) check_val("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          exp_e = sb.pop_front();
          check_val("parity_byte", 32'({prev_pv, prev_data}), 32'(exp_e));
        end
      end
      if (pkt_valid) run_len++;
      else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (pkt_valid && pld_ready) overlap++;
      if (pld_ready) pld_rdy_seen++;
    end else begin
      run_len = 0;
    end
    prev_pv   = pkt_valid;
    prev_data = data_out;
    prev_busy = busy;
  end

  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len, input bit gaps,
                          input int busy_idx, input int busy_cyc, input int rst_idx,
                          input bit inj);
    logic [7:0] p;
    bit acc, done, busy_done;
    int cyc, n_acc, t0;
    p = {len, addr};
    sb.push_back({1'b1, p});
    for (int i = 0; i < int'(len); i++) begin
      sb.push_back({1'b1, pld_buf[i]});
      p = p ^ pld_buf[i];
    end
    if (inj) p = ~p;
    sb.push_back({1'b0, p});
    overlap = 0;
    pld_rdy_seen = 0;
    req_addr = addr;
    req_len  = len;
`ifdef ROUTER_TX_PAR_INJ_EN
    par_inj = inj;
`endif
    req_valid = 1'b1;
    acc = 0; cyc = 0;
    while (!acc && cyc < 50) begin
      acc = req_ready;
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0;
    check_val("req_accept", 32'(acc), 32'd1);
    n_acc = 0;
    for (int i = 0; i < int'(len); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        pld_valid = 1'b0;
        @(posedge clk); #1;
      end
      pld_valid = 1'b1;
      pld_data  = pld_buf[i];
      acc = 0; cyc = 0;
      while (!acc && cyc < 50) begin
        acc = pld_ready;
        @(posedge clk); #1;
        cyc++;
      end
      pld_valid = 1'b0;
      if (acc) n_acc++;
      else break;
    end
    check_val("pld_accepted", 32'(n_acc), 32'(len));
    done = 0; busy_done = 0; cyc = 0;
    while (!done && cyc < 500) begin
      if (rst_idx >= 0 && pkt_valid && data_out == pld_buf[rst_idx]) begin
        t0 = tx_cnt;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_val("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_data_out", 32'(data_out), 32'd0);
        check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check_val("rst_no_tx_done", 32'(tx_cnt), 32'(t0));
        sb.delete();
        return;
      end
      if (busy_idx >= 0 && !busy_done && pkt_valid && data_out == pld_buf[busy_idx]) begin
        busy = 1'b1;
        for (int k = 0; k < busy_cyc; k++) begin
          @(posedge clk); #1;
          check_val("busy_hold_data", 32'(data_out), 32'(pld_buf[busy_idx]));
          check_val("busy_hold_pv", 32'(pkt_valid), 32'd1);
        end
        busy = 1'b0;
        busy_done = 1;
      end
      if (tx_done) done = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_val("tx_done_seen", 32'(done), 32'd1);
    @(negedge clk); #1;
    check_val("run_len", 32'(last_run), 32'(int'(len) + 1 + (busy_done ? busy_cyc : 0)));
    check_val("fill_overlap", 32'(overlap), 32'd0);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    if (len == 0) check_val("len0_pld_ready", 32'(pld_rdy_seen), 32'd0);
    @(posedge clk); #1;
    check_val("tx_done_pulse", 32'(tx_done), 32'd0);
  endtask

  task automatic load_std();
    pld_buf[0] = 8'h11;
    pld_buf[1] = 8'h22;
    pld_buf[2] = 8'h33;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_pld_ready", 32'(pld_ready), 32'd0);
    check_val("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check_val("rst_data_out", 32'(data_out), 32'd0);
    check_val("rst_tx_done", 32'(tx_done), 32'd0);
    check_val("rst_err_cnt", 32'(err_cnt), 32'd0);

    err = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("err_cnt_10", 32'(err_cnt), 32'd10);
    repeat (290) @(posedge clk);
    #1;
    check_val("err_cnt_sat", 32'(err_cnt), 32'd255);
    err = 1'b0;

    // addr 1, len 3: header 0x0D, parity 0x0D
    load_std();
    send_pkt(2'd1, 6'd3, 1'b0, -1, 0, -1, 1'b0);
    // same packet, router busy for 2 cycles on 0x22
    send_pkt(2'd1, 6'd3, 1'b0, 1, 2, -1, 1'b0);
    // empty payload
    send_pkt(2'd2, 6'd0, 1'b0, -1, 0, -1, 1'b0);
    // maximum length with payload gaps
    for (int i = 0; i < 63; i++) pld_buf[i] = 8'($urandom_range(0, 255));
    send_pkt(2'd0, 6'd63, 1'b1, -1, 0, -1, 1'b0);
    // illegal destination is passed through unchanged
    pld_buf[0] = 8'h5A;
    pld_buf[1] = 8'hC3;
    send_pkt(2'd3, 6'd2, 1'b1, -1, 0, -1, 1'b0);
    // reset mid-payload, then a clean packet
    for (int i = 0; i < 5; i++) pld_buf[i] = 8'(8'hA1 + i);
    send_pkt(2'd1, 6'd5, 1'b0, -1, 0, 2, 1'b0);
    load_std();
    send_pkt(2'd1, 6'd3, 1'b0, -1, 0, -1, 1'b0);
`ifdef ROUTER_TX_PAR_INJ_EN
    send_pkt(2'd1, 6'd3, 1'b0, -1, 0, -1, 1'b1);
    send_pkt(2'd1, 6'd3, 1'b0, -1, 0, -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low
- req_valid  in  1  packet request
- req_ready  out  1  request accepted when both high
- req_addr  in  2  destination port 0..2
- req_len  in  6  payload bytes 0..63
- pld_valid  in  1  payload byte valid
- pld_ready  out  1  payload byte accepted when both high
- pld_data  in  8  payload byte
- busy  in  1  router busy; hold current byte
- data_out  out  8  byte to router
- pkt_valid  out  1  high during header and payload
- tx_done  out  1  one-cycle pulse, packet complete
- err  in  1  router parity-error flag
- err_cnt  out  8  saturating count of err-high cycles
REQ-002 SHALL treat req_addr==3 as illegal: request accepted and packet sent unchanged; destination handling is the router's concern.

Function
REQ-003 SHALL implement states IDLE, FILL, HEADER, PAYLOAD, PARITY, DONE.
REQ-004 IDLE: req_ready=1; on req_valid, SHALL latch addr/len, set parity register = {len,addr}, go FILL (len>0) or HEADER (len==0).
REQ-005 FILL: pld_ready=1; each accepted byte SHALL be written to buffer[wr_idx], wr_idx++; after byte len-1 go HEADER; no bytes sent to router during FILL.
REQ-006 HEADER: data_out={len,addr}, pkt_valid=1; at an edge with busy==0 go PAYLOAD (len>0) or PARITY (len==0).
REQ-007 PAYLOAD: data_out=buffer[rd_idx], pkt_valid=1; at an edge with busy==0 SHALL XOR byte into parity, rd_idx++; after byte len-1 go PARITY.
REQ-008 PARITY: pkt_valid=0, data_out=parity register; at an edge with busy==0 go DONE.
REQ-009 DONE: tx_done=1 for exactly one cycle, then IDLE; req_ready=0 in DONE.
REQ-010 A byte SHALL be consumed only at a posedge where busy==0 in HEADER/PAYLOAD/PARITY; while busy==1, data_out and pkt_valid SHALL hold unchanged.
REQ-011 pkt_valid SHALL never deassert between header and last payload byte; the gap-free stream is guaranteed by buffering the full packet.
REQ-012 req_ready and pld_ready SHALL be 0 outside IDLE and FILL respectively.
REQ-013 data_out SHALL be 0 in IDLE, FILL and DONE.
REQ-014 err_cnt SHALL increment on each clk edge with err==1, saturate at 255, and be independent of state.
REQ-015 Header-to-parity latency with busy held low SHALL be len+1 cycles; tx_done follows parity by one cycle.

Reset
REQ-016 On rst==0 at posedge: state=IDLE, wr_idx=rd_idx=0, parity=0, err_cnt=0; after the edge req_ready=1, pld_ready=0, pkt_valid=0, data_out=0, tx_done=0.
REQ-017 Reset mid-packet SHALL abandon the packet with no tx_done; buffer contents are not cleared.

Configuration
REQ-018 Macro ROUTER_TX_PAR_INJ_EN defined: extra input par_inj (1 bit) sampled at request acceptance; when 1, the PARITY byte SHALL be ~parity.
REQ-019 Macro undefined: no par_inj port; parity always correct.

Structure
REQ-020 Shared package router_pkg SHALL hold the state encoding typedef, ROUTER_MAX_LEN=63, and header field widths (addr 2, len 6).
REQ-021 Payload storage SHALL be the sub-module router_tx_buf: 64x8 register array, one synchronous write port, one asynchronous read port, no reset on contents.

Verification
REQ-022 addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0, tx_done next cycle.
REQ-023 Same packet, busy=1 for 2 cycles during the 0x22 byte -> 0x22 held 3 cycles, sequence and parity unchanged.
REQ-024 addr=2, len=0 -> header 0x02 with pkt_valid=1, parity 0x02, tx_done; pld_ready never asserted.
REQ-025 addr=0, len=63, payload with pld_valid gaps -> no bytes sent until 63 accepted, then 64 contiguous pkt_valid cycles and correct XOR parity.
REQ-026 rst=0 during PAYLOAD of len=5 -> next cycle IDLE, pkt_valid=0, no tx_done; a following packet is sent correctly.
REQ-027 err held high 300 cycles -> err_cnt=255; with ROUTER_TX_PAR_INJ_EN and par_inj=1 on REQ-022 packet -> parity byte 0xF2.
